rtc_set_ctrl: RTL and testbench

Button-driven time-setting controller for the real-time clock top level. It synchronises and debounces the three push buttons (left, right, up) and runs a field-select state machine. It drives the clock counters with run-enable, field-select and single-cycle increment pulses, and drives a digit blank mask to the 7-segment multiplexer so the field being edited blinks.

---
 rtl/rtc_set_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rtc_set_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: time-setting controller for the RTC top level. It conditions the
// left, right and up buttons, steps the field-select FSM, and drives increment pulses and the blink mask.
module rtc_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100,
  parameter int unsigned REPEAT_CYCLES   = 5000,
  parameter int unsigned BLINK_CYCLES    = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btnl_i,
  input  logic       btnr_i,
  input  logic       btnu_i,
  output logic       run_o,
  output logic       edit_o,
  output logic [1:0] field_o,
  output logic       inc_o,
  output logic [7:0] blank_mask_o
);

  localparam int NUM_BTN = 3;
  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_U   = 2;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W = (REPEAT_CYCLES   > 1) ? $clog2(REPEAT_CYCLES)   : 1;
  localparam int BL_W = (BLINK_CYCLES    > 1) ? $clog2(BLINK_CYCLES)    : 1;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  logic               btnu_level;

  assign btn_raw = {btnu_i, btnr_i, btnl_i};

  // Per-button lane: 2-FF sync, debounce, then a registered rise pulse.
  // db_d is the debounced level delayed to line up with the press pulse.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            db;
    logic            db_d;
    logic            press;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        db     <= 1'b0;
        db_d   <= 1'b0;
        press  <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync1 <= btn_raw[i];
        sync2 <= sync1;
        if (sync2 != db) begin
          if (db_cnt == DB_MAX) begin
            db     <= sync2;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
        db_d  <= db;
        press <= db & ~db_d;
      end
    end

    assign btn_press[i] = press;

    if (i == BTN_U) begin : g_lvl
      assign btnu_level = db_d;
    end
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET_H = 2'd1,
    S_SET_M = 2'd2,
    S_SET_S = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [RP_W-1:0] rep_cnt;
  logic [RP_W-1:0] rep_cnt_n;
  logic [BL_W-1:0] blk_cnt;
  logic [BL_W-1:0] blk_cnt_n;
  logic            phase;
  logic            phase_n;
  logic            inc_n;
  logic            chg;
  logic            fwd;
  logic            bwd;
  logic [1:0]      field_n;
  logic [7:0]      mask_n;

  // Simultaneous left and right presses cancel each other.
  assign fwd = btn_press[BTN_R] & ~btn_press[BTN_L];
  assign bwd = btn_press[BTN_L] & ~btn_press[BTN_R];

  always_comb begin
    state_n = state;
    case (state)
      S_RUN:   if (fwd) state_n = S_SET_H; else if (bwd) state_n = S_SET_S;
      S_SET_H: if (fwd) state_n = S_SET_M; else if (bwd) state_n = S_RUN;
      S_SET_M: if (fwd) state_n = S_SET_S; else if (bwd) state_n = S_SET_H;
      S_SET_S: if (fwd) state_n = S_RUN;   else if (bwd) state_n = S_SET_M;
      default: state_n = S_RUN;
    endcase
    chg = (state_n != state);

    // A move always beats an increment; the repeat count restarts on any move or release.
    inc_n     = 1'b0;
    rep_cnt_n = '0;
    if (!chg && (state != S_RUN) && btnu_level) begin
      if (btn_press[BTN_U] || (rep_cnt == RP_MAX)) begin
        inc_n = 1'b1;
      end else begin
        rep_cnt_n = rep_cnt + 1'b1;
      end
    end

    blk_cnt_n = blk_cnt + 1'b1;
    phase_n   = phase;
    if (chg) begin
      blk_cnt_n = '0;
      phase_n   = 1'b0;
    end else if (blk_cnt == BL_MAX) begin
      blk_cnt_n = '0;
      phase_n   = ~phase;
    end

    case (state_n)
      S_SET_H: field_n = 2'd2;
      S_SET_M: field_n = 2'd1;
      default: field_n = 2'd0;
    endcase

    mask_n = '0;
    if ((state_n != S_RUN) && phase_n) mask_n[{field_n, 1'b0} +: 2] = 2'b11;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_RUN;
      rep_cnt      <= '0;
      blk_cnt      <= '0;
      phase        <= 1'b0;
      run_o        <= 1'b1;
      edit_o       <= 1'b0;
      field_o      <= 2'd0;
      inc_o        <= 1'b0;
      blank_mask_o <= '0;
    end else begin
      state        <= state_n;
      rep_cnt      <= rep_cnt_n;
      blk_cnt      <= blk_cnt_n;
      phase        <= phase_n;
      run_o        <= (state_n == S_RUN);
      edit_o       <= (state_n != S_RUN);
      field_o      <= field_n;
      inc_o        <= inc_n;
      blank_mask_o <= mask_n;
    end
  end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Self-checking bench for rtc_set_ctrl: directed scenarios with literal expectations
// plus randomized button activity compared every cycle against a timestamp-based model.
module tb_rtc_set_ctrl;
  localparam int D = 4;
  localparam int R = 20;
  localparam int B = 8;

  logic       clk = 1'b0;
  logic       rst_i, btnl, btnr, btnu;
  logic       run_o, edit_o, inc_o;
  logic [1:0] field_o;
  logic [7:0] blank_mask_o;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  rtc_set_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .BLINK_CYCLES(B)) dut (
    .clk_i(clk), .rst_i(rst_i), .btnl_i(btnl), .btnr_i(btnr), .btnu_i(btnu),
    .run_o(run_o), .edit_o(edit_o), .field_o(field_o), .inc_o(inc_o),
    .blank_mask_o(blank_mask_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT on each rising edge.
  bit [2:0] smp_raw;
  bit       smp_rst;
  always @(posedge clk) begin
    smp_raw <= {btnu, btnr, btnl};
    smp_rst <= rst_i;
  end

  // Model: raw level reaches the debouncer 2 edges late; the debounced level flips after
  // D consecutive disagreeing edges; its rise acts on the FSM 2 edges after it flips.
  // Repeat and blink are expressed as timestamps relative to the last move.
  int       cyc = 0, st = 0, enter_c = 0, due_c = 0, nst = 0, ph = 0, m_field = 0;
  bit       rh1[3], rh2[3], dbm[3], dbB[3], dbC[3], prs[3];
  int       dis[3];
  bit       syn, lvl_u, m_run, m_edit, m_inc;
  logic [7:0] m_mask;

  always @(negedge clk) begin
    cyc++;
    if (smp_rst) begin
      st = 0; m_inc = 0; enter_c = cyc; due_c = cyc + R;
      for (int b = 0; b < 3; b++) begin
        rh1[b] = 0; rh2[b] = 0; dbm[b] = 0; dbB[b] = 0; dbC[b] = 0; dis[b] = 0;
      end
    end else begin
      for (int b = 0; b < 3; b++) prs[b] = dbB[b] && !dbC[b];
      lvl_u = dbB[2];
      for (int b = 0; b < 3; b++) begin
        syn = rh2[b]; rh2[b] = rh1[b]; rh1[b] = smp_raw[b];
        dbC[b] = dbB[b]; dbB[b] = dbm[b];
        if (syn != dbm[b]) begin
          dis[b]++;
          if (dis[b] == D) begin dbm[b] = syn; dis[b] = 0; end
        end else dis[b] = 0;
      end
      nst = st;
      if (prs[1] && !prs[0]) nst = (st + 1) % 4;
      else if (prs[0] && !prs[1]) nst = (st + 3) % 4;
      m_inc = 0;
      if (nst != st || st == 0 || !lvl_u) due_c = cyc + R;
      else if (prs[2] || cyc == due_c) begin m_inc = 1; due_c = cyc + R; end
      if (nst != st) enter_c = cyc;
      st = nst;
    end
    m_run   = (st == 0);
    m_edit  = (st != 0);
    m_field = (st == 1) ? 2 : (st == 2) ? 1 : 0;
    ph      = ((cyc - enter_c) / B) % 2;
    m_mask  = (st != 0 && ph == 1) ? (8'h03 << (2 * m_field)) : 8'h00;
    if (chk_en) begin
      chk("cyc_run",   run_o,        m_run);
      chk("cyc_edit",  edit_o,       m_edit);
      chk("cyc_field", field_o,      m_field);
      chk("cyc_inc",   inc_o,        m_inc);
      chk("cyc_mask",  blank_mask_o, m_mask);
    end
  end

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (inc_o === 1'b1) pulses++;
    end
  endtask

  // Press for 10 cycles, release for 10; the move must land on the 8th falling edge
  // (edge index D+3 after the first sampling edge) and not one earlier.
  task automatic step(input bit l, input bit r, input bit u, input int pe, input int pf,
                      input int ee, input int ef, input string nm, output int pulses);
    pulses = 0;
    btnl = l; btnr = r; btnu = u;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (inc_o === 1'b1) pulses++;
      if (k == 7) begin
        chk({nm, "_pre_edit"},  edit_o,  pe);
        chk({nm, "_pre_field"}, field_o, pf);
      end
      if (k == 8) begin
        chk({nm, "_edit"},  edit_o,  ee);
        chk({nm, "_field"}, field_o, ef);
        chk({nm, "_run"},   run_o,   (ee == 0) ? 1 : 0);
      end
      if (k == 10) begin btnl = 0; btnr = 0; btnu = 0; end
    end
  endtask

  initial begin
    int pc, p2, np;
    int pos[4];
    rst_i = 1; btnl = 0; btnr = 0; btnu = 0;
    @(negedge clk);
    rst_i = 0; chk_en = 1;
    chk("rst_run", run_o, 1);
    chk("rst_edit", edit_o, 0);
    chk("rst_field", field_o, 0);
    chk("rst_inc", inc_o, 0);
    chk("rst_mask", blank_mask_o, 8'h00);
    idle(50, pc);
    chk("idle_inc", pc, 0);
    chk("idle_edit", edit_o, 0);

    // forward walk
    step(0, 1, 0, 0, 0, 1, 2, "fwd_h", pc);
    step(0, 1, 0, 1, 2, 1, 1, "fwd_m", pc);
    step(0, 1, 0, 1, 1, 1, 0, "fwd_s", pc);
    step(0, 1, 0, 1, 0, 0, 0, "fwd_run", pc);

    // bounce: 2-cycle pulses are shorter than the debounce window
    pc = 0;
    for (int i = 0; i < 10; i++) begin
      btnr = ~btnr;
      idle(2, p2);
      pc += p2;
    end
    btnr = 0;
    idle(20, p2);
    chk("bounce_inc", pc + p2, 0);
    chk("bounce_edit", edit_o, 0);

    // increment and auto-repeat in SET_M
    step(0, 1, 0, 0, 0, 1, 2, "inc_to_h", pc);
    step(0, 1, 0, 1, 2, 1, 1, "inc_to_m", pc);
    for (int i = 0; i < 4; i++) pos[i] = -1;
    np = 0;
    btnu = 1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (inc_o === 1'b1) begin
        if (np < 4) pos[np] = k - 1;
        np++;
        chk("rep_field", field_o, 1);
      end
      if (k == 70) btnu = 0;
    end
    chk("rep_count", np, 4);
    chk("rep_p0", pos[0], 7);
    chk("rep_p1", pos[1], 27);
    chk("rep_p2", pos[2], 47);
    chk("rep_p3", pos[3], 67);

    // btnu in RUN is ignored
    step(0, 1, 0, 1, 1, 1, 0, "inc_to_s", pc);
    step(0, 1, 0, 1, 0, 0, 0, "inc_to_run", pc);
    btnu = 1;
    idle(40, pc);
    btnu = 0;
    idle(10, p2);
    chk("run_btnu_inc", pc + p2, 0);

    // simultaneous events
    btnl = 1; btnr = 1;
    idle(10, pc);
    btnl = 0; btnr = 0;
    idle(10, p2);
    chk("lr_edit", edit_o, 0);
    chk("lr_run", run_o, 1);
    step(0, 1, 0, 0, 0, 1, 2, "sim_to_h", pc);
    step(0, 1, 1, 1, 2, 1, 1, "ur_to_m", pc);
    chk("ur_no_inc", pc, 0);

    // blink after stepping back to SET_H
    btnl = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) btnl = 0;
      if (k == 8)  begin chk("blk_field", field_o, 2); chk("blk_k8", blank_mask_o, 8'h00); end
      if (k == 15) chk("blk_k15", blank_mask_o, 8'h00);
      if (k == 16) chk("blk_k16", blank_mask_o, 8'h30);
      if (k == 23) chk("blk_k23", blank_mask_o, 8'h30);
      if (k == 24) chk("blk_k24", blank_mask_o, 8'h00);
      if (k == 32) chk("blk_k32", blank_mask_o, 8'h30);
    end

    // mid-edit reset with btnu held
    btnu = 1;
    idle(12, pc);
    chk("pre_rst_inc", pc, 1);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk("mrst_run", run_o, 1);
    chk("mrst_edit", edit_o, 0);
    chk("mrst_field", field_o, 0);
    chk("mrst_inc", inc_o, 0);
    chk("mrst_mask", blank_mask_o, 8'h00);
    idle(30, pc);
    chk("post_rst_inc", pc, 0);
    chk("post_rst_edit", edit_o, 0);
    btnu = 0;
    idle(10, pc);

    // randomized activity, checked by the per-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) btnl = ~btnl;
      if ($urandom_range(0, 11) == 0) btnr = ~btnr;
      if ($urandom_range(0, 15) == 0) btnu = ~btnu;
      rst_i = ($urandom_range(0, 1499) == 0);
    end
    rst_i = 0; btnl = 0; btnr = 0; btnu = 0;
    idle(20, pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
